icb_mst_seq: RTL and testbench
==============================

# icb_mst_seq

ICB initiator that turns one local burst request into a sequence of single-outstanding ICB word accesses. It is the command-issuing end of the same ICB link that the DSO control/measure register block responds on. Typical uses are firmware-free parameter loading and bulk readback of measure registers. Write data is streamed in, read data is streamed out, and completion and error status are reported per request.

## Interface
Parameters:
- `TO_CYC`, default 256: cycles without handshake progress before a timeout abort. Counter width is `$clog2(TO_CYC+1)`.
- `WR_RSP`, default 1: 1 means a write beat waits for an ICB response; 0 means a write beat completes at the cmd handshake, for responders that answer reads only.

Ports (reset values listed under Operation):
- `clk` in 1: single clock. One clock; reset is asynchronous and active-low.
- `rst_n` in 1: asynchronous, active-low reset.
- `req_valid` in 1, `req_ready` out 1: burst request handshake.
- `req_read` in 1: 1 selects a read burst, 0 a write burst.
- `req_addr` in 32: first beat address.
- `req_len` in 4: number of beats minus 1 (1 to 16 beats).
- `wd_valid` in 1, `wd_ready` out 1, `wd_data` in 32, `wd_mask` in 4: write-data stream.
- `rd_valid` out 1, `rd_ready` in 1, `rd_data` out 32, `rd_last` out 1: read-data stream.
- `busy` out 1: request in progress.
- `done` out 1: one-cycle completion pulse.
- `err` out 1: error flag, held until the next request is accepted.
- `to_flag` out 1: set together with `err` when the cause was a timeout.
- `m_icb_cmd_valid` out 1, `m_icb_cmd_ready` in 1, `m_icb_cmd_addr` out 32, `m_icb_cmd_read` out 1, `m_icb_cmd_wdata` out 32, `m_icb_cmd_wmask` out 4: ICB command channel.
- `m_icb_rsp_valid` in 1, `m_icb_rsp_ready` out 1, `m_icb_rsp_err` in 1, `m_icb_rsp_rdata` in 32: ICB response channel.

## Operation
- **FSM states:** IDLE, WDAT, CMD, RSP.
- **IDLE:**
  - `req_ready`=1.
  - On `req_valid`, latch `req_read`, `req_addr`, and `req_len` into the beat counter.
  - Clear `err` and `to_flag`.
  - Go to WDAT for a write or CMD for a read.
- **WDAT:**
  - `wd_ready`=1.
  - On `wd_valid`, latch `wd_data`/`wd_mask` into the cmd registers and go to CMD.
- **CMD:**
  - `m_icb_cmd_valid`=1; addr, read, wdata and wmask come from registers and are stable while valid is high.
  - On `m_icb_cmd_ready`: a read goes to RSP. A write goes to RSP if `WR_RSP`=1; otherwise it completes the beat.
- **RSP:**
  - `m_icb_rsp_ready` equals `rd_ready` for reads and 1 for writes.
  - For reads, `rd_valid`=`m_icb_rsp_valid` and `rd_data`=`m_icb_rsp_rdata`, both combinational.
  - A response handshake completes the beat.
- **Beat completion:**
  - If the beat completes with `m_icb_rsp_err`=1, or it was the final beat, go to IDLE and pulse `done`; `err` is set on an error.
  - Otherwise decrement the beat count, add 4 to the address (mod 2^32, low 2 bits kept as given), and go to WDAT or CMD.
- **`rd_last`:** 1 with `rd_valid` on the final beat or on an erroring read beat. That beat's data is still delivered.
- **Error abort:** remaining beats are not issued, and no further `wd_ready` is given for them.
- **Reset values:**
  - 0: `m_icb_cmd_valid`, `m_icb_rsp_ready`, `wd_ready`, `rd_valid`, `rd_last`, `busy`, `done`, `err`, `to_flag`, cmd addr/wdata/wmask/read.
  - 1: `req_ready`.
- **Reset mid-burst:** an asynchronous reset aborts immediately. No `done` pulse, and the FSM returns to IDLE.
- **`busy`:** 1 in every state except IDLE.

## Timing
- Request accepted at edge T:
  - Read: `m_icb_cmd_valid` is high from T+1.
  - Write: `wd_ready` is high from T+1, and `m_icb_cmd_valid` follows one cycle after the `wd_valid` handshake.
- A zero-wait responder gives a throughput of 2 cycles per read beat and 3 cycles per write beat (`WR_RSP`=1).
- `done` is asserted the cycle after the final completing handshake. `req_ready` returns in that same cycle.
- A `req_valid` presented while `done` is high is accepted, which gives back-to-back bursts.
- A `m_icb_rsp_valid` that arrives while in CMD is ignored: `m_icb_rsp_ready`=0 there.

## Configuration
- `ICB_MST_TIMEOUT_EN` defined:
  - A counter clears on every state change and counts cycles spent in CMD or RSP.
  - On reaching `TO_CYC` it forces IDLE the next cycle and drops `m_icb_cmd_valid` / `m_icb_rsp_ready`, an abort-only exception to the valid-hold rule.
  - It sets `err`=1 and `to_flag`=1 and pulses `done`.
  - WDAT is not timed.
- `ICB_MST_TIMEOUT_EN` undefined: no counter, waits indefinitely, and `to_flag` is tied to 0.

## Test plan
- **Read burst:** `req_addr`=0x0000_0018, `req_len`=3, responder has zero wait with rdata=addr.
  - Cmd addrs are 0x18/0x1C/0x20/0x24 and `rd_data` matches them.
  - `rd_last` is high only on 0x24; `done` comes 1 cycle later with `err`=0.
- **Write burst:** `req_len`=1, wd stream 0x7F then 0x01, `WR_RSP`=1.
  - Wdata 0x7F is sent to addr A and 0x01 to A+4, masks passed through; `done`, `err`=0.
- **Write with `WR_RSP`=0 and a read-only responder:** 2-beat write completes without any `m_icb_rsp_valid`, and `done` pulses.
- **Error mid-burst:** 4-beat read with `m_icb_rsp_err`=1 on beat 2.
  - Beat 2 is delivered with `rd_last`=1, and no third cmd is issued.
  - `done` and `err`=1, `to_flag`=0.
- **Backpressure and wrap:** `rd_ready` held low 5 cycles on beat 1, with `req_addr`=0xFFFF_FFFC and `req_len`=1.
  - `m_icb_rsp_ready` stays low during those 5 cycles.
  - The second cmd addr is 0x0000_0000.
- **Timeout (`ICB_MST_TIMEOUT_EN`, `TO_CYC`=8):** `m_icb_cmd_ready` is held at 0.
  - `m_icb_cmd_valid` drops after 8 cycles; `done`, `err`=1, `to_flag`=1.
  - Asserting `rst_n`=0 mid-CMD clears all outputs in the same cycle.

Source files
------------

// File: rtl/icb_mst_seq.sv
// ICB initiator: splits one local burst request into single-outstanding ICB word beats.
// Define ICB_MST_TIMEOUT_EN to add the CMD/RSP stall timeout (TO_CYC cycles).
module icb_mst_seq #(
    parameter int unsigned TO_CYC = 256,
    parameter bit          WR_RSP = 1'b1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_read,
    input  logic [31:0] req_addr,
    input  logic [3:0]  req_len,
    input  logic        wd_valid,
    output logic        wd_ready,
    input  logic [31:0] wd_data,
    input  logic [3:0]  wd_mask,
    output logic        rd_valid,
    input  logic        rd_ready,
    output logic [31:0] rd_data,
    output logic        rd_last,
    output logic        busy,
    output logic        done,
    output logic        err,
    output logic        to_flag,
    output logic        m_icb_cmd_valid,
    input  logic        m_icb_cmd_ready,
    output logic [31:0] m_icb_cmd_addr,
    output logic        m_icb_cmd_read,
    output logic [31:0] m_icb_cmd_wdata,
    output logic [3:0]  m_icb_cmd_wmask,
    input  logic        m_icb_rsp_valid,
    output logic        m_icb_rsp_ready,
    input  logic        m_icb_rsp_err,
    input  logic [31:0] m_icb_rsp_rdata
);

    typedef enum logic [1:0] {StIdle, StWdat, StCmd, StRsp} state_e;

    state_e      state_q, state_d;
    logic        read_q, read_d;
    logic [31:0] addr_q, addr_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [31:0] wdata_q, wdata_d;
    logic [3:0]  wmask_q, wmask_d;
    logic        err_q, err_d;
    logic        done_q, done_d;
    logic        rsp_hs, beat_done, beat_err;

`ifdef ICB_MST_TIMEOUT_EN
    localparam int unsigned    ToW    = $clog2(TO_CYC + 1);
    localparam logic [ToW-1:0] ToLast = ToW'(TO_CYC - 1);
    logic [ToW-1:0] tcnt_q, tcnt_d;
    logic           to_q, to_d;
`else
    logic unused_to_cyc;
    assign unused_to_cyc = ^TO_CYC;
`endif

    assign req_ready       = (state_q == StIdle);
    assign busy            = (state_q != StIdle);
    assign wd_ready        = (state_q == StWdat);
    assign m_icb_cmd_valid = (state_q == StCmd);
    assign m_icb_cmd_addr  = addr_q;
    assign m_icb_cmd_read  = read_q;
    assign m_icb_cmd_wdata = wdata_q;
    assign m_icb_cmd_wmask = wmask_q;
    // Read responses are only accepted when the local consumer can take them.
    assign m_icb_rsp_ready = (state_q == StRsp) && (read_q ? rd_ready : 1'b1);
    assign rd_valid        = (state_q == StRsp) && read_q && m_icb_rsp_valid;
    assign rd_data         = m_icb_rsp_rdata;
    assign rd_last         = rd_valid && (m_icb_rsp_err || (cnt_q == 4'd0));
    assign done            = done_q;
    assign err             = err_q;

    always_comb begin
        rsp_hs    = (state_q == StRsp) && m_icb_rsp_valid && m_icb_rsp_ready;
        beat_err  = rsp_hs && m_icb_rsp_err;
        beat_done = rsp_hs ||
                    ((state_q == StCmd) && m_icb_cmd_ready && !WR_RSP && !read_q);
    end

    always_comb begin
        state_d = state_q;
        read_d  = read_q;
        addr_d  = addr_q;
        cnt_d   = cnt_q;
        wdata_d = wdata_q;
        wmask_d = wmask_q;
        err_d   = err_q;
        done_d  = 1'b0;
`ifdef ICB_MST_TIMEOUT_EN
        to_d    = to_q;
        tcnt_d  = tcnt_q;
`endif
        case (state_q)
            StIdle: begin
                if (req_valid) begin
                    read_d  = req_read;
                    addr_d  = req_addr;
                    cnt_d   = req_len;
                    err_d   = 1'b0;
`ifdef ICB_MST_TIMEOUT_EN
                    to_d    = 1'b0;
`endif
                    state_d = req_read ? StCmd : StWdat;
                end
            end
            StWdat: begin
                if (wd_valid) begin
                    wdata_d = wd_data;
                    wmask_d = wd_mask;
                    state_d = StCmd;
                end
            end
            StCmd: begin
                if (m_icb_cmd_ready && (read_q || WR_RSP)) state_d = StRsp;
            end
            default: ;
        endcase

        if (beat_done) begin
            if (beat_err || (cnt_q == 4'd0)) begin
                state_d = StIdle;
                done_d  = 1'b1;
                err_d   = beat_err;
            end else begin
                cnt_d   = cnt_q - 4'd1;
                addr_d  = addr_q + 32'd4;
                state_d = read_q ? StCmd : StWdat;
            end
        end

`ifdef ICB_MST_TIMEOUT_EN
        // Every handshake changes state, so an unchanged CMD/RSP state means no progress.
        if ((state_q == StCmd || state_q == StRsp) && (state_d == state_q) &&
            (tcnt_q == ToLast)) begin
            state_d = StIdle;
            done_d  = 1'b1;
            err_d   = 1'b1;
            to_d    = 1'b1;
        end
        if (state_d != state_q) begin
            tcnt_d = '0;
        end else if (state_q == StCmd || state_q == StRsp) begin
            tcnt_d = tcnt_q + ToW'(1);
        end else begin
            tcnt_d = '0;
        end
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            read_q  <= 1'b0;
            addr_q  <= '0;
            cnt_q   <= '0;
            wdata_q <= '0;
            wmask_q <= '0;
            err_q   <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            read_q  <= read_d;
            addr_q  <= addr_d;
            cnt_q   <= cnt_d;
            wdata_q <= wdata_d;
            wmask_q <= wmask_d;
            err_q   <= err_d;
            done_q  <= done_d;
        end
    end

`ifdef ICB_MST_TIMEOUT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tcnt_q <= '0;
            to_q   <= 1'b0;
        end else begin
            tcnt_q <= tcnt_d;
            to_q   <= to_d;
        end
    end
    assign to_flag = to_q;
`else
    assign to_flag = 1'b0;
`endif

endmodule

// File: tb/tb_icb_mst_seq.sv
// Directed bench for icb_mst_seq: table of read bursts plus hand sequences for write,
// backpressure/wrap, WR_RSP=0, reset mid-burst and (with ICB_MST_TIMEOUT_EN) timeout.
module tb_icb_mst_seq;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic        req_valid, req_read;
    logic [31:0] req_addr;
    logic [3:0]  req_len;
    logic        wd_valid;
    logic [31:0] wd_data;
    logic [3:0]  wd_mask;
    logic        rd_ready;
    logic        cmd_rdy;
    logic        rsp_vld, rsp_err;
    logic [31:0] rsp_data;

    logic        req_ready, wd_ready, rd_valid, rd_last, busy, done, err, to_flag;
    logic [31:0] rd_data;
    logic        m_icb_cmd_valid, m_icb_cmd_read, m_icb_rsp_ready;
    logic [31:0] m_icb_cmd_addr, m_icb_cmd_wdata;
    logic [3:0]  m_icb_cmd_wmask;

    // Second instance: WR_RSP=0 against a responder that never answers.
    logic        b_req_valid, b_wd_valid, b_cmd_rdy, b_rsp_vld, b_rsp_err;
    logic [31:0] b_wd_data, b_rsp_data;
    logic        b_req_ready, b_wd_ready, b_rd_valid, b_rd_last, b_busy, b_done, b_err, b_to;
    logic [31:0] b_rd_data, b_cmd_addr, b_cmd_wdata;
    logic        b_cmd_valid, b_cmd_read, b_rsp_ready;
    logic [3:0]  b_cmd_wmask;

    icb_mst_seq #(.TO_CYC(8), .WR_RSP(1'b1)) u_dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_read(req_read),
        .req_addr(req_addr), .req_len(req_len),
        .wd_valid(wd_valid), .wd_ready(wd_ready), .wd_data(wd_data), .wd_mask(wd_mask),
        .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_data(rd_data), .rd_last(rd_last),
        .busy(busy), .done(done), .err(err), .to_flag(to_flag),
        .m_icb_cmd_valid(m_icb_cmd_valid), .m_icb_cmd_ready(cmd_rdy),
        .m_icb_cmd_addr(m_icb_cmd_addr), .m_icb_cmd_read(m_icb_cmd_read),
        .m_icb_cmd_wdata(m_icb_cmd_wdata), .m_icb_cmd_wmask(m_icb_cmd_wmask),
        .m_icb_rsp_valid(rsp_vld), .m_icb_rsp_ready(m_icb_rsp_ready),
        .m_icb_rsp_err(rsp_err), .m_icb_rsp_rdata(rsp_data)
    );

    icb_mst_seq #(.TO_CYC(8), .WR_RSP(1'b0)) u_dut_b (
        .clk(clk), .rst_n(rst_n),
        .req_valid(b_req_valid), .req_ready(b_req_ready), .req_read(req_read),
        .req_addr(req_addr), .req_len(req_len),
        .wd_valid(b_wd_valid), .wd_ready(b_wd_ready), .wd_data(b_wd_data), .wd_mask(wd_mask),
        .rd_valid(b_rd_valid), .rd_ready(rd_ready), .rd_data(b_rd_data), .rd_last(b_rd_last),
        .busy(b_busy), .done(b_done), .err(b_err), .to_flag(b_to),
        .m_icb_cmd_valid(b_cmd_valid), .m_icb_cmd_ready(b_cmd_rdy),
        .m_icb_cmd_addr(b_cmd_addr), .m_icb_cmd_read(b_cmd_read),
        .m_icb_cmd_wdata(b_cmd_wdata), .m_icb_cmd_wmask(b_cmd_wmask),
        .m_icb_rsp_valid(b_rsp_vld), .m_icb_rsp_ready(b_rsp_ready),
        .m_icb_rsp_err(b_rsp_err), .m_icb_rsp_rdata(b_rsp_data)
    );

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [31:0] cmd_addr_log[$];
    logic [31:0] cmd_wdata_log[$];
    logic [3:0]  cmd_mask_log[$];
    logic        cmd_read_log[$];
    int          cmd_cyc_log[$];
    logic [31:0] rd_data_log[$];
    logic        rd_last_log[$];
    int          rd_cyc_log[$];
    logic [31:0] b_addr_log[$];
    logic [31:0] b_wdata_log[$];
    int          done_cnt = 0;
    int          done_cyc = 0;
    logic        done_err = 1'b0;
    logic        done_to = 1'b0;
    int          b_done_cnt = 0;
    logic        b_done_err = 1'b0;
    int          err_beat = -1;
    logic        pend_cmd = 1'b0;
    logic        pend_rsp = 1'b0;
    logic        pend_err = 1'b0;
    logic [31:0] pend_addr = '0;

    // Monitor: samples handshakes mid-cycle; they complete at the next rising edge.
    always @(negedge clk) begin
        pend_cmd = m_icb_cmd_valid && cmd_rdy;
        pend_rsp = rsp_vld && m_icb_rsp_ready;
        if (pend_cmd) begin
            pend_err  = (cmd_addr_log.size() == err_beat);
            pend_addr = m_icb_cmd_addr;
            cmd_addr_log.push_back(m_icb_cmd_addr);
            cmd_wdata_log.push_back(m_icb_cmd_wdata);
            cmd_mask_log.push_back(m_icb_cmd_wmask);
            cmd_read_log.push_back(m_icb_cmd_read);
            cmd_cyc_log.push_back(cyc);
        end
        if (rd_valid && rd_ready) begin
            rd_data_log.push_back(rd_data);
            rd_last_log.push_back(rd_last);
            rd_cyc_log.push_back(cyc);
        end
        if (done) begin
            done_cnt = done_cnt + 1;
            done_cyc = cyc;
            done_err = err;
            done_to  = to_flag;
        end
        if (b_cmd_valid && b_cmd_rdy) begin
            b_addr_log.push_back(b_cmd_addr);
            b_wdata_log.push_back(b_cmd_wdata);
        end
        if (b_done) begin
            b_done_cnt = b_done_cnt + 1;
            b_done_err = b_err;
        end
    end

    // Zero-wait responder: answers each command in the following cycle with rdata = addr.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_vld  <= 1'b0;
            rsp_err  <= 1'b0;
            rsp_data <= '0;
        end else begin
            if (pend_rsp) rsp_vld <= 1'b0;
            if (pend_cmd) begin
                rsp_vld  <= 1'b1;
                rsp_data <= pend_addr;
                rsp_err  <= pend_err;
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total = total + 1;
        if (act !== exp) begin
            bad = bad + 1;
            $display("FAIL %s: got %h, want %h", name, act, exp);
        end
    endtask

    function automatic logic [10:0] ctrl_bits();
        return {req_ready, m_icb_cmd_valid, m_icb_rsp_ready, wd_ready, rd_valid, rd_last,
                busy, done, err, to_flag, m_icb_cmd_read};
    endfunction

    task automatic clear_logs();
        cmd_addr_log.delete();
        cmd_wdata_log.delete();
        cmd_mask_log.delete();
        cmd_read_log.delete();
        cmd_cyc_log.delete();
        rd_data_log.delete();
        rd_last_log.delete();
        rd_cyc_log.delete();
    endtask

    task automatic start_req(input logic rd, input logic [31:0] a, input logic [3:0] l);
        @(posedge clk);
        #1;
        req_valid = 1'b1;
        req_read  = rd;
        req_addr  = a;
        req_len   = l;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (req_ready) break;
        end
        check("req_accept", req_ready, 1);
        @(posedge clk);
        #1;
        req_valid = 1'b0;
    endtask

    task automatic wait_done(input int d0, input string name);
        for (int k = 0; k < 200 && done_cnt == d0; k++) @(posedge clk);
        check(name, done_cnt - d0, 1);
    endtask

    typedef struct {
        logic [31:0] addr;
        logic [3:0]  len;
        int          err_beat;
        int          exp_cmds;
        logic [31:0] exp_last;
        logic        exp_err;
    } vec_t;

    localparam int NV = 6;
    vec_t vecs[NV];

    task automatic run_read(input vec_t v, input int idx);
        int d0, n, m;
        clear_logs();
        err_beat = v.err_beat;
        d0 = done_cnt;
        start_req(1'b1, v.addr, v.len);
        @(negedge clk);
        check($sformatf("v%0d_cmd_valid_t1", idx), m_icb_cmd_valid, 1);
        wait_done(d0, $sformatf("v%0d_done", idx));
        n = cmd_addr_log.size();
        m = rd_data_log.size();
        check($sformatf("v%0d_ncmd", idx), n, v.exp_cmds);
        if (n > 0) check($sformatf("v%0d_last_addr", idx), cmd_addr_log[n-1], v.exp_last);
        for (int i = 0; i < n; i++) begin
            check($sformatf("v%0d_addr%0d", idx, i), cmd_addr_log[i], v.addr + 32'(4 * i));
        end
        check($sformatf("v%0d_nrd", idx), m, v.exp_cmds);
        for (int i = 0; i < m; i++) begin
            check($sformatf("v%0d_rdata%0d", idx, i), rd_data_log[i], v.addr + 32'(4 * i));
            check($sformatf("v%0d_rlast%0d", idx, i), rd_last_log[i], (i == m - 1));
        end
        check($sformatf("v%0d_err", idx), done_err, v.exp_err);
        check($sformatf("v%0d_to", idx), done_to, 0);
        if (m > 0) check($sformatf("v%0d_done_lat", idx), done_cyc - rd_cyc_log[m-1], 1);
        if (n > 1) begin
            check($sformatf("v%0d_tput", idx), cmd_cyc_log[n-1] - cmd_cyc_log[0], 2 * (n - 1));
        end
        repeat (3) @(posedge clk);
        check($sformatf("v%0d_err_held", idx), err, v.exp_err);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog expired");
    end

    initial begin
        int d0, n;
        rst_n = 1'b0;
        req_valid = 1'b0; req_read = 1'b0; req_addr = '0; req_len = '0;
        wd_valid = 1'b0; wd_data = '0; wd_mask = '0;
        rd_ready = 1'b1; cmd_rdy = 1'b1;
        b_req_valid = 1'b0; b_wd_valid = 1'b0; b_wd_data = 32'hCAFE_0001;
        b_cmd_rdy = 1'b1; b_rsp_vld = 1'b0; b_rsp_err = 1'b0; b_rsp_data = '0;

        //          addr           len   errb cmds last           err
        vecs[0] = '{32'h0000_0018, 4'd3,  -1, 4,  32'h0000_0024, 1'b0};
        vecs[1] = '{32'h0000_1000, 4'd3,   1, 2,  32'h0000_1004, 1'b1};
        vecs[2] = '{32'h0000_0003, 4'd0,  -1, 1,  32'h0000_0003, 1'b0};
        vecs[3] = '{32'h0000_0040, 4'd15, -1, 16, 32'h0000_007C, 1'b0};
        vecs[4] = '{32'hFFFF_FFF8, 4'd2,  -1, 3,  32'h0000_0000, 1'b0};
        vecs[5] = '{32'h0000_2000, 4'd2,   0, 1,  32'h0000_2000, 1'b1};

        repeat (3) @(negedge clk);
        check("rst_ctrl", ctrl_bits(), 11'b100_0000_0000);
        check("rst_cmd_addr", m_icb_cmd_addr, 0);
        check("rst_cmd_wdata", m_icb_cmd_wdata, 0);
        check("rst_cmd_wmask", m_icb_cmd_wmask, 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        for (int i = 0; i < NV; i++) run_read(vecs[i], i);

        // Write burst, WR_RSP=1: 0x7F then 0x01 with distinct masks.
        clear_logs();
        err_beat = -1;
        d0 = done_cnt;
        start_req(1'b0, 32'h0000_0100, 4'd1);
        wd_valid = 1'b1; wd_data = 32'h0000_007F; wd_mask = 4'h3;
        @(negedge clk);
        check("wr_wd_ready_t1", wd_ready, 1);
        @(posedge clk);
        #1;
        wd_data = 32'h0000_0001; wd_mask = 4'hC;
        @(negedge clk);
        check("wr_cmd_after_wd", m_icb_cmd_valid, 1);
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (wd_ready) break;
        end
        check("wr_wd_ready_b1", wd_ready, 1);
        @(posedge clk);
        #1;
        wd_valid = 1'b0;
        wait_done(d0, "wr_done");
        n = cmd_addr_log.size();
        check("wr_ncmd", n, 2);
        if (n == 2) begin
            check("wr_addr0", cmd_addr_log[0], 32'h0000_0100);
            check("wr_addr1", cmd_addr_log[1], 32'h0000_0104);
            check("wr_data0", cmd_wdata_log[0], 32'h0000_007F);
            check("wr_data1", cmd_wdata_log[1], 32'h0000_0001);
            check("wr_mask0", cmd_mask_log[0], 4'h3);
            check("wr_mask1", cmd_mask_log[1], 4'hC);
            check("wr_read", {cmd_read_log[0], cmd_read_log[1]}, 2'b00);
            check("wr_tput", cmd_cyc_log[1] - cmd_cyc_log[0], 3);
        end
        check("wr_err", done_err, 0);

        // Backpressure on beat 1 plus address wrap.
        clear_logs();
        d0 = done_cnt;
        rd_ready = 1'b0;
        start_req(1'b1, 32'hFFFF_FFFC, 4'd1);
        for (int k = 0; k < 20; k++) begin
            if (rd_valid) break;
            @(negedge clk);
        end
        check("bp_rd_valid", rd_valid, 1);
        for (int k = 0; k < 5; k++) begin
            check($sformatf("bp_rsp_ready%0d", k), m_icb_rsp_ready, 0);
            if (k < 4) @(negedge clk);
        end
        @(posedge clk);
        #1;
        rd_ready = 1'b1;
        wait_done(d0, "bp_done");
        n = cmd_addr_log.size();
        check("bp_ncmd", n, 2);
        if (n == 2) check("bp_wrap_addr", cmd_addr_log[1], 32'h0000_0000);
        check("bp_nrd", rd_data_log.size(), 2);
        if (rd_data_log.size() == 2) check("bp_rdata1", rd_data_log[1], 32'h0000_0000);
        check("bp_err", done_err, 0);

        // WR_RSP=0 instance: a 2-beat write completes with no response at all.
        d0 = b_done_cnt;
        b_addr_log.delete();
        b_wdata_log.delete();
        @(posedge clk);
        #1;
        b_req_valid = 1'b1; req_read = 1'b0; req_addr = 32'h0000_0300; req_len = 4'd1;
        b_wd_valid = 1'b1;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (b_req_ready) break;
        end
        @(posedge clk);
        #1;
        b_req_valid = 1'b0;
        for (int k = 0; k < 50 && b_done_cnt == d0; k++) @(posedge clk);
        check("nr_done", b_done_cnt - d0, 1);
        check("nr_ncmd", b_addr_log.size(), 2);
        if (b_addr_log.size() == 2) begin
            check("nr_addr1", b_addr_log[1], 32'h0000_0304);
            check("nr_wdata", b_wdata_log[1], 32'hCAFE_0001);
        end
        check("nr_err", b_done_err, 0);
        #1;
        b_wd_valid = 1'b0;

`ifdef ICB_MST_TIMEOUT_EN
        // Command never accepted: abort after TO_CYC cycles of cmd_valid.
        clear_logs();
        d0 = done_cnt;
        @(posedge clk);
        #1;
        cmd_rdy = 1'b0;
        start_req(1'b1, 32'h0000_0050, 4'd0);
        n = 0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (!m_icb_cmd_valid) break;
            n = n + 1;
        end
        @(posedge clk);
        check("to_valid_cycles", n, 8);
        check("to_done", done_cnt - d0, 1);
        check("to_err", done_err, 1);
        check("to_flag", done_to, 1);
        #1;
        cmd_rdy = 1'b1;
`endif

        // Asynchronous reset while stuck in CMD.
        @(posedge clk);
        #1;
        cmd_rdy = 1'b0;
        start_req(1'b1, 32'h0000_0060, 4'd2);
        repeat (2) @(negedge clk);
        check("rst_pre_cmd", m_icb_cmd_valid, 1);
        #2;
        rst_n = 1'b0;
        #1;
        check("rst_mid_ctrl", ctrl_bits(), 11'b100_0000_0000);
        check("rst_mid_addr", m_icb_cmd_addr, 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        cmd_rdy = 1'b1;
        d0 = done_cnt;
        repeat (5) @(posedge clk);
        check("rst_no_done", done_cnt, d0);
        check("rst_idle", req_ready, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
